// File: rtl/eth_stats_pkg.sv
// Shared types for the MAC statistics block: raw vector layouts, field positions
// and the decoded per-frame event carried between pipeline stages.
package eth_stats_pkg;

  localparam int RX_STAT_W = 30;
  localparam int TX_STAT_W = 26;
  localparam int LEN_W     = 15;

  localparam int RX_GOOD_BIT = 0;
  localparam int RX_BAD_BIT  = 1;
  localparam int RX_FCS_BIT  = 2;
  localparam int RX_LEN_LSB  = 3;
  localparam int RX_LEN_MSB  = 17;

  localparam int TX_GOOD_BIT = 0;
  localparam int TX_BAD_BIT  = 1;
  localparam int TX_LEN_LSB  = 2;
  localparam int TX_LEN_MSB  = 16;

  typedef struct packed {
    logic [11:0]      rsvd;
    logic [LEN_W-1:0] len;
    logic             fcs_err;
    logic             bad;
    logic             good;
  } rx_stat_t;

  typedef struct packed {
    logic [8:0]       ign;
    logic [LEN_W-1:0] len;
    logic             bad;
    logic             good;
  } tx_stat_t;

  typedef struct packed {
    logic             vld;
    logic             good;
    logic             bad;
    logic             fcs;
    logic [LEN_W-1:0] len;
  } stat_evt_t;

  // Fields are forced to zero when the qualifier is low so stale vector bits never count.
  function automatic stat_evt_t rx_decode(input logic [RX_STAT_W-1:0] v, input logic vld);
    stat_evt_t e;
    e = '0;
    if (vld) begin
      e.vld  = 1'b1;
      e.good = v[RX_GOOD_BIT];
      e.bad  = v[RX_BAD_BIT];
      e.fcs  = v[RX_FCS_BIT];
      e.len  = v[RX_LEN_MSB:RX_LEN_LSB];
    end
    return e;
  endfunction

  function automatic stat_evt_t tx_decode(input logic [TX_STAT_W-1:0] v, input logic vld);
    stat_evt_t e;
    e = '0;
    if (vld) begin
      e.vld  = 1'b1;
      e.good = v[TX_GOOD_BIT];
      e.bad  = v[TX_BAD_BIT];
      e.len  = v[TX_LEN_MSB:TX_LEN_LSB];
    end
    return e;
  endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// Saturating event counter; one-cycle update, no backpressure.
// A clear loads the same-cycle increment so an event coinciding with a snapshot is kept.
module eth_stat_counter
  import eth_stats_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk156,
  input  logic         sys_rst,
  input  logic         i_inc_en,
  input  logic [W-1:0] i_inc_val,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;
  logic [W-1:0] r_cnt;

  assign w_sum = {1'b0, r_cnt} + {1'b0, i_inc_val};
  assign w_sat = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= i_inc_en ? i_inc_val : '0;
    end else if (i_inc_en) begin
      r_cnt <= w_sat;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_mac_stats.sv
// MAC TX/RX statistics accumulator with atomic snapshot; events land in live counters
// two cycles after their valid, snapshot outputs two cycles after snap_req; never stalls.
module eth_mac_stats
  import eth_stats_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int BYTE_W        = 48,
  parameter bit CLEAR_ON_SNAP = 1'b1
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  input  logic                 rx_statistics_valid,
  input  logic [RX_STAT_W-1:0] rx_statistics_vector,
  input  logic                 tx_statistics_valid,
  input  logic [TX_STAT_W-1:0] tx_statistics_vector,
  input  logic                 snap_req,
  output logic                 snap_done,
  output logic [CNT_W-1:0]     rx_good_frames,
  output logic [CNT_W-1:0]     rx_bad_frames,
  output logic [CNT_W-1:0]     rx_fcs_errors,
  output logic [BYTE_W-1:0]    rx_good_bytes,
  output logic [CNT_W-1:0]     tx_good_frames,
  output logic [CNT_W-1:0]     tx_bad_frames,
  output logic [BYTE_W-1:0]    tx_good_bytes
);

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  stat_evt_t r_rx_evt;
  stat_evt_t r_tx_evt;
  logic      r_snap_pend;
  logic      r_snap_done;
  logic      w_clear;

  logic [CNT_W-1:0]  w_rx_good_frames, w_rx_bad_frames, w_rx_fcs_errors;
  logic [CNT_W-1:0]  w_tx_good_frames, w_tx_bad_frames;
  logic [BYTE_W-1:0] w_rx_good_bytes, w_tx_good_bytes;

  logic [CNT_W-1:0]  r_rx_good_frames, r_rx_bad_frames, r_rx_fcs_errors;
  logic [CNT_W-1:0]  r_tx_good_frames, r_tx_bad_frames;
  logic [BYTE_W-1:0] r_rx_good_bytes, r_tx_good_bytes;

  logic w_rx_byte_en;
  logic w_tx_byte_en;
  logic w_unused_ok;

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_evt <= '0;
      r_tx_evt <= '0;
    end else begin
      r_rx_evt <= rx_decode(rx_statistics_vector, rx_statistics_valid);
      r_tx_evt <= tx_decode(tx_statistics_vector, tx_statistics_valid);
    end
  end

  // A request arriving while one is pending folds into it, giving a single snap_done.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_snap_pend <= 1'b0;
      r_snap_done <= 1'b0;
    end else begin
      r_snap_pend <= snap_req & ~r_snap_pend;
      r_snap_done <= r_snap_pend;
    end
  end

  assign w_clear      = r_snap_pend & CLEAR_ON_SNAP;
  assign w_rx_byte_en = r_rx_evt.vld & r_rx_evt.good & ~r_rx_evt.bad;
  assign w_tx_byte_en = r_tx_evt.vld & r_tx_evt.good & ~r_tx_evt.bad;

  eth_stat_counter #(.W(CNT_W)) u_rx_good_frames (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(r_rx_evt.vld & r_rx_evt.good), .i_inc_val(ONE_C),
    .i_clear(w_clear), .o_cnt(w_rx_good_frames)
  );

  eth_stat_counter #(.W(CNT_W)) u_rx_bad_frames (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(r_rx_evt.vld & r_rx_evt.bad), .i_inc_val(ONE_C),
    .i_clear(w_clear), .o_cnt(w_rx_bad_frames)
  );

  eth_stat_counter #(.W(CNT_W)) u_rx_fcs_errors (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(r_rx_evt.vld & r_rx_evt.fcs), .i_inc_val(ONE_C),
    .i_clear(w_clear), .o_cnt(w_rx_fcs_errors)
  );

  eth_stat_counter #(.W(BYTE_W)) u_rx_good_bytes (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(w_rx_byte_en), .i_inc_val(BYTE_W'(r_rx_evt.len)),
    .i_clear(w_clear), .o_cnt(w_rx_good_bytes)
  );

  eth_stat_counter #(.W(CNT_W)) u_tx_good_frames (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(r_tx_evt.vld & r_tx_evt.good), .i_inc_val(ONE_C),
    .i_clear(w_clear), .o_cnt(w_tx_good_frames)
  );

  eth_stat_counter #(.W(CNT_W)) u_tx_bad_frames (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(r_tx_evt.vld & r_tx_evt.bad), .i_inc_val(ONE_C),
    .i_clear(w_clear), .o_cnt(w_tx_bad_frames)
  );

  eth_stat_counter #(.W(BYTE_W)) u_tx_good_bytes (
    .clk156(clk156), .sys_rst(sys_rst),
    .i_inc_en(w_tx_byte_en), .i_inc_val(BYTE_W'(r_tx_evt.len)),
    .i_clear(w_clear), .o_cnt(w_tx_good_bytes)
  );

  // Copy sees the live values before this edge's increment lands.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_good_frames <= '0;
      r_rx_bad_frames  <= '0;
      r_rx_fcs_errors  <= '0;
      r_rx_good_bytes  <= '0;
      r_tx_good_frames <= '0;
      r_tx_bad_frames  <= '0;
      r_tx_good_bytes  <= '0;
    end else if (r_snap_pend) begin
      r_rx_good_frames <= w_rx_good_frames;
      r_rx_bad_frames  <= w_rx_bad_frames;
      r_rx_fcs_errors  <= w_rx_fcs_errors;
      r_rx_good_bytes  <= w_rx_good_bytes;
      r_tx_good_frames <= w_tx_good_frames;
      r_tx_bad_frames  <= w_tx_bad_frames;
      r_tx_good_bytes  <= w_tx_good_bytes;
    end
  end

  assign snap_done      = r_snap_done;
  assign rx_good_frames = r_rx_good_frames;
  assign rx_bad_frames  = r_rx_bad_frames;
  assign rx_fcs_errors  = r_rx_fcs_errors;
  assign rx_good_bytes  = r_rx_good_bytes;
  assign tx_good_frames = r_tx_good_frames;
  assign tx_bad_frames  = r_tx_bad_frames;
  assign tx_good_bytes  = r_tx_good_bytes;

  assign w_unused_ok = ^{rx_statistics_vector[RX_STAT_W-1:RX_LEN_MSB+1],
                         tx_statistics_vector[TX_STAT_W-1:TX_LEN_MSB+1],
                         r_tx_evt.fcs};

endmodule

// File: tb/tb_eth_mac_stats.sv
// Directed bench for eth_mac_stats: default instance for function and snapshot timing,
// a narrow CLEAR_ON_SNAP=0 instance for saturation.
`timescale 1ns/1ps
module tb_eth_mac_stats;
  import eth_stats_pkg::*;

  logic clk156 = 1'b0;
  logic sys_rst;
  always #5 clk156 = ~clk156;

  logic                 rx_valid, tx_valid, snap_req, snap_done;
  logic [RX_STAT_W-1:0] rx_vec;
  logic [TX_STAT_W-1:0] tx_vec;
  logic [31:0]          rx_good_frames, rx_bad_frames, rx_fcs_errors, tx_good_frames, tx_bad_frames;
  logic [47:0]          rx_good_bytes, tx_good_bytes;

  logic                 b_rx_valid, b_tx_valid, b_snap_req, b_snap_done;
  logic [RX_STAT_W-1:0] b_rx_vec;
  logic [TX_STAT_W-1:0] b_tx_vec;
  logic [3:0]           b_rx_good_frames, b_rx_bad_frames, b_rx_fcs_errors, b_tx_good_frames, b_tx_bad_frames;
  logic [15:0]          b_rx_good_bytes, b_tx_good_bytes;

  int n_chk  = 0;
  int n_fail = 0;

  eth_mac_stats dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .rx_statistics_valid(rx_valid), .rx_statistics_vector(rx_vec),
    .tx_statistics_valid(tx_valid), .tx_statistics_vector(tx_vec),
    .snap_req(snap_req), .snap_done(snap_done),
    .rx_good_frames(rx_good_frames), .rx_bad_frames(rx_bad_frames),
    .rx_fcs_errors(rx_fcs_errors), .rx_good_bytes(rx_good_bytes),
    .tx_good_frames(tx_good_frames), .tx_bad_frames(tx_bad_frames),
    .tx_good_bytes(tx_good_bytes)
  );

  eth_mac_stats #(.CNT_W(4), .BYTE_W(16), .CLEAR_ON_SNAP(1'b0)) dut_b (
    .clk156(clk156), .sys_rst(sys_rst),
    .rx_statistics_valid(b_rx_valid), .rx_statistics_vector(b_rx_vec),
    .tx_statistics_valid(b_tx_valid), .tx_statistics_vector(b_tx_vec),
    .snap_req(b_snap_req), .snap_done(b_snap_done),
    .rx_good_frames(b_rx_good_frames), .rx_bad_frames(b_rx_bad_frames),
    .rx_fcs_errors(b_rx_fcs_errors), .rx_good_bytes(b_rx_good_bytes),
    .tx_good_frames(b_tx_good_frames), .tx_bad_frames(b_tx_bad_frames),
    .tx_good_bytes(b_tx_good_bytes)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  function automatic logic [RX_STAT_W-1:0] rxv(input logic g, input logic b, input logic f, input int len);
    rx_stat_t s;
    s.rsvd    = 12'hABC;
    s.len     = LEN_W'(len);
    s.fcs_err = f;
    s.bad     = b;
    s.good    = g;
    return s;
  endfunction

  function automatic logic [TX_STAT_W-1:0] txv(input logic g, input logic b, input int len);
    tx_stat_t s;
    s.ign  = 9'h1A5;
    s.len  = LEN_W'(len);
    s.bad  = b;
    s.good = g;
    return s;
  endfunction

  task automatic rx_frame(input logic g, input logic b, input logic f, input int len);
    rx_valid = 1'b1;
    rx_vec   = rxv(g, b, f, len);
    tick();
    rx_valid = 1'b0;
    rx_vec   = '0;
  endtask

  task automatic tx_frame(input logic g, input logic b, input int len);
    tx_valid = 1'b1;
    tx_vec   = txv(g, b, len);
    tick();
    tx_valid = 1'b0;
    tx_vec   = '0;
  endtask

  // Called one cycle after snap_req was first driven high; checks 2-cycle latency and 1-cycle pulse.
  task automatic wait_done(input string tag, input bit use_b);
    int lat;
    lat = 1;
    while (!(use_b ? b_snap_done : snap_done) && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, ".snap_lat"}, 64'(lat), 64'd2);
    tick();
    chk({tag, ".snap_pulse"}, 64'(use_b ? b_snap_done : snap_done), 64'd0);
  endtask

  task automatic snap(input string tag);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    wait_done(tag, 1'b0);
  endtask

  task automatic snap_b(input string tag);
    b_snap_req = 1'b1;
    tick();
    b_snap_req = 1'b0;
    wait_done(tag, 1'b1);
  endtask

  task automatic exp7(input string tag, input logic [63:0] rgf, input logic [63:0] rbf,
                      input logic [63:0] rfe, input logic [63:0] rgb, input logic [63:0] tgf,
                      input logic [63:0] tbf, input logic [63:0] tgb);
    chk({tag, ".rx_good_frames"}, 64'(rx_good_frames), rgf);
    chk({tag, ".rx_bad_frames"},  64'(rx_bad_frames),  rbf);
    chk({tag, ".rx_fcs_errors"},  64'(rx_fcs_errors),  rfe);
    chk({tag, ".rx_good_bytes"},  64'(rx_good_bytes),  rgb);
    chk({tag, ".tx_good_frames"}, 64'(tx_good_frames), tgf);
    chk({tag, ".tx_bad_frames"},  64'(tx_bad_frames),  tbf);
    chk({tag, ".tx_good_bytes"},  64'(tx_good_bytes),  tgb);
  endtask

  initial begin
    int pulses;
    sys_rst  = 1'b1;
    rx_valid = 1'b0; rx_vec = '0; tx_valid = 1'b0; tx_vec = '0; snap_req = 1'b0;
    b_rx_valid = 1'b0; b_rx_vec = '0; b_tx_valid = 1'b0; b_tx_vec = '0; b_snap_req = 1'b0;
    #1;
    chk("rst.snap_done", 64'(snap_done), 64'd0);
    exp7("rst", 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    sys_rst = 1'b0;
    tick();

    // Three good RX frames: 64 + 1518 + 9000 = 10582 bytes.
    rx_frame(1, 0, 0, 64);
    rx_frame(1, 0, 0, 1518);
    rx_frame(1, 0, 0, 9000);
    snap("rx3");
    exp7("rx3", 3, 0, 0, 10582, 0, 0, 0);

    rx_frame(0, 1, 1, 100);
    snap("badfcs");
    exp7("badfcs", 0, 1, 1, 0, 0, 0, 0);

    // FCS without bad, plus good+bad together: both frame counters, no bytes.
    rx_frame(0, 0, 1, 300);
    rx_frame(1, 1, 0, 200);
    snap("indep");
    exp7("indep", 1, 1, 1, 0, 0, 0, 0);

    repeat (5) tx_frame(1, 0, 64);
    tx_valid = 1'b1;
    tx_vec   = txv(1, 0, 64);
    snap_req = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_vec   = '0;
    snap_req = 1'b0;
    wait_done("coincide", 1'b0);
    exp7("coincide", 0, 0, 0, 0, 5, 0, 320);
    snap("carry");
    exp7("carry", 0, 0, 0, 0, 1, 0, 64);

    rx_valid = 1'b1; rx_vec = rxv(1, 0, 0, 70);
    tx_valid = 1'b1; tx_vec = txv(0, 1, 80);
    tick();
    rx_valid = 1'b0; rx_vec = '0; tx_valid = 1'b0; tx_vec = '0;
    snap("both");
    exp7("both", 1, 0, 0, 70, 0, 1, 0);

    rx_vec = '1;
    tx_vec = '1;
    repeat (10) tick();
    rx_vec = '0;
    tx_vec = '0;
    snap("novld");
    exp7("novld", 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back requests collapse into one snapshot.
    tx_frame(1, 0, 100);
    snap_req = 1'b1;
    tick();
    tick();
    snap_req = 1'b0;
    pulses = int'(snap_done);
    repeat (6) begin
      tick();
      pulses += int'(snap_done);
    end
    chk("absorb.pulses", 64'(pulses), 64'd1);
    chk("absorb.tx_good_frames", 64'(tx_good_frames), 64'd1);
    chk("absorb.tx_good_bytes", 64'(tx_good_bytes), 64'd100);

    rx_frame(1, 0, 0, 64);
    rx_frame(1, 0, 0, 64);
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    sys_rst  = 1'b1;
    #1;
    chk("midrst.snap_done", 64'(snap_done), 64'd0);
    exp7("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk156);
    #1;
    sys_rst = 1'b0;
    pulses  = 0;
    repeat (5) begin
      tick();
      pulses += int'(snap_done);
    end
    chk("midrst.pulses", 64'(pulses), 64'd0);
    exp7("postrst", 0, 0, 0, 0, 0, 0, 0);
    rx_frame(1, 0, 0, 64);
    snap("resume");
    exp7("resume", 1, 0, 0, 64, 0, 0, 0);

    // Narrow instance: 14 frames (one below max), then 3 more must stick at all-ones.
    repeat (14) begin
      b_rx_valid = 1'b1;
      b_rx_vec   = rxv(1, 0, 0, 9000);
      tick();
    end
    b_rx_valid = 1'b0;
    b_rx_vec   = '0;
    snap_b("sat1");
    chk("sat1.rx_good_frames", 64'(b_rx_good_frames), 64'hE);
    chk("sat1.rx_good_bytes", 64'(b_rx_good_bytes), 64'hFFFF);
    repeat (3) begin
      b_rx_valid = 1'b1;
      b_rx_vec   = rxv(1, 0, 0, 64);
      tick();
    end
    b_rx_valid = 1'b0;
    b_rx_vec   = '0;
    snap_b("sat2");
    chk("sat2.rx_good_frames", 64'(b_rx_good_frames), 64'hF);
    chk("sat2.rx_good_bytes", 64'(b_rx_good_bytes), 64'hFFFF);
    chk("sat2.rx_bad_frames", 64'(b_rx_bad_frames), 64'h0);
    chk("sat2.tx_good_frames", 64'(b_tx_good_frames), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
